// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU internal bus arbitration logic:
// arbiter state encoding, bus mux select constants and the default bus width.
package cpu_bus_pkg;

    localparam int BUS_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2to1_nb.sv
// WIDTH-bit 2:1 mux assembled from independent 1-bit 2:1 muxes.
// sel = 0 passes a, sel = 1 passes b.
module mux_2to1_nb #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // One single-bit mux per bus bit, all sharing the same select.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = sel ? b[i] : a[i];
    end

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Two-requester bus arbiter. A 3-state FSM decides ownership with a
// round-robin tie break and a hold limit under contention, drives the select
// of the shared 2:1 bus mux and registers the selected payload with a valid.
module bus_arbiter_2to1
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH    = BUS_WIDTH,
    parameter int MAX_HOLD = 4
) (
    input  logic             input_clock,
    input  logic             input_reset_n,
    input  logic             input_request_a,
    input  logic             input_request_b,
    input  logic [WIDTH-1:0] input_data_a,
    input  logic [WIDTH-1:0] input_data_b,
    output logic             output_grant_a,
    output logic             output_grant_b,
    output logic             output_select,
    output logic [WIDTH-1:0] output_data,
    output logic             output_valid
);

    // The counter only needs to reach MAX_HOLD-1; keep at least one bit.
    localparam int                HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_count;
    logic              last_served;
    logic [WIDTH-1:0]  mux_data;

    // Grants decode straight from the state register, so they are glitch-free
    // and can never both be high.
    assign output_grant_a = (state == OWN_A);
    assign output_grant_b = (state == OWN_B);

    mux_2to1_nb #(
        .WIDTH (WIDTH)
    ) u_bus_mux (
        .sel (output_select),
        .a   (input_data_a),
        .b   (input_data_b),
        .y   (mux_data)
    );

    // Ownership FSM with hold-limit counter, round-robin pointer and mux select.
    // NOTE: every register here uses <= so all reads see pre-edge values.
    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            state         <= IDLE;
            hold_count    <= '0;
            last_served   <= SEL_B;
            output_select <= SEL_A;
        end else begin
            case (state)
                IDLE: begin
                    hold_count <= '0;
                    if (input_request_a && (!input_request_b || last_served == SEL_B)) begin
                        state         <= OWN_A;
                        last_served   <= SEL_A;
                        output_select <= SEL_A;
                    end else if (input_request_b) begin
                        state         <= OWN_B;
                        last_served   <= SEL_B;
                        output_select <= SEL_B;
                    end
                end
                OWN_A: begin
                    if (input_request_b && (!input_request_a || hold_count == HOLD_LAST)) begin
                        state         <= OWN_B;
                        hold_count    <= '0;
                        last_served   <= SEL_B;
                        output_select <= SEL_B;
                    end else if (!input_request_a) begin
                        state      <= IDLE;
                        hold_count <= '0;
                    end else if (hold_count != HOLD_LAST) begin
                        hold_count <= hold_count + HOLD_W'(1);
                    end
                end
                OWN_B: begin
                    if (input_request_a && (!input_request_b || hold_count == HOLD_LAST)) begin
                        state         <= OWN_A;
                        hold_count    <= '0;
                        last_served   <= SEL_A;
                        output_select <= SEL_A;
                    end else if (!input_request_b) begin
                        state      <= IDLE;
                        hold_count <= '0;
                    end else if (hold_count != HOLD_LAST) begin
                        hold_count <= hold_count + HOLD_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    hold_count <= '0;
                end
            endcase
        end
    end

    // Data stage: capture the owner's payload while it keeps requesting.
    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            output_data  <= '0;
            output_valid <= 1'b0;
        end else if ((state == OWN_A && input_request_a) ||
                     (state == OWN_B && input_request_b)) begin
            output_data  <= mux_data;
            output_valid <= 1'b1;
        end else begin
            output_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench for bus_arbiter_2to1. Two instances (MAX_HOLD=4 and
// MAX_HOLD=1) share the same stimulus; each is compared every cycle against
// an ownership-level reference model, plus directed spot checks.
module tb_bus_arbiter_2to1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ra    = 1'b0;
    logic       rb    = 1'b0;
    logic [7:0] da    = 8'h00;
    logic [7:0] db    = 8'h00;

    logic       ga4, gb4, sel4, vld4;
    logic [7:0] dat4;
    logic       ga1, gb1, sel1, vld1;
    logic [7:0] dat1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0: MAX_HOLD=4, index 1: MAX_HOLD=1.
    // owner: 0 = nobody, 1 = A, 2 = B. run = cycles the owner has held the bus.
    int         m_owner [2];
    int         m_run   [2];
    int         m_last  [2];
    int         m_maxh  [2];
    logic       m_sel   [2];
    logic       m_valid [2];
    logic [7:0] m_data  [2];

    bus_arbiter_2to1 #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .input_clock     (clk),
        .input_reset_n   (rst_n),
        .input_request_a (ra),
        .input_request_b (rb),
        .input_data_a    (da),
        .input_data_b    (db),
        .output_grant_a  (ga4),
        .output_grant_b  (gb4),
        .output_select   (sel4),
        .output_data     (dat4),
        .output_valid    (vld4)
    );

    bus_arbiter_2to1 #(.WIDTH(8), .MAX_HOLD(1)) dut_alt (
        .input_clock     (clk),
        .input_reset_n   (rst_n),
        .input_request_a (ra),
        .input_request_b (rb),
        .input_data_a    (da),
        .input_data_b    (db),
        .output_grant_a  (ga1),
        .output_grant_b  (gb1),
        .output_select   (sel1),
        .output_data     (dat1),
        .output_valid    (vld1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_maxh[0] = 4;
        m_maxh[1] = 1;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = 0;
            m_run[m]   = 0;
            m_last[m]  = 2;
            m_sel[m]   = 1'b0;
            m_valid[m] = 1'b0;
            m_data[m]  = 8'h00;
        end
    endtask

    // One clock edge of the arbitration rules, applied to the sampled inputs.
    task automatic model_step(input int m);
        int nxt;
        if (m_owner[m] == 1 && ra) begin
            m_valid[m] = 1'b1;
            m_data[m]  = da;
        end else if (m_owner[m] == 2 && rb) begin
            m_valid[m] = 1'b1;
            m_data[m]  = db;
        end else begin
            m_valid[m] = 1'b0;
        end

        nxt = m_owner[m];
        case (m_owner[m])
            0: begin
                if (ra && rb) nxt = (m_last[m] == 1) ? 2 : 1;
                else if (ra)  nxt = 1;
                else if (rb)  nxt = 2;
                else          nxt = 0;
            end
            1: begin
                if (!ra)                            nxt = rb ? 2 : 0;
                else if (rb && m_run[m] >= m_maxh[m]) nxt = 2;
            end
            default: begin
                if (!rb)                            nxt = ra ? 1 : 0;
                else if (ra && m_run[m] >= m_maxh[m]) nxt = 1;
            end
        endcase

        if (nxt == 0) begin
            m_run[m] = 0;
        end else if (nxt != m_owner[m]) begin
            m_run[m]  = 1;
            m_last[m] = nxt;
            m_sel[m]  = (nxt == 2);
        end else begin
            m_run[m]++;
        end
        m_owner[m] = nxt;
    endtask

    task automatic compare_inst(input string name, input int m, input logic ga, input logic gb,
                                input logic sel, input logic vld, input logic [7:0] dat);
        check({name, ".grant_a"}, ga, m_owner[m] == 1);
        check({name, ".grant_b"}, gb, m_owner[m] == 2);
        check({name, ".exclusive"}, ga & gb, 0);
        check({name, ".select"}, sel, m_sel[m]);
        check({name, ".valid"}, vld, m_valid[m]);
        check({name, ".data"}, dat, m_data[m]);
    endtask

    task automatic compare_all();
        compare_inst("hold4", 0, ga4, gb4, sel4, vld4, dat4);
        compare_inst("hold1", 1, ga1, gb1, sel1, vld1, dat1);
    endtask

    // Advance one clock: model follows the edge, outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end else begin
            model_reset();
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".grant_a"}, ga4 | ga1, 0);
        check({tag, ".grant_b"}, gb4 | gb1, 0);
        check({tag, ".select"}, sel4 | sel1, 0);
        check({tag, ".valid"}, vld4 | vld1, 0);
        check({tag, ".data"}, dat4 | dat1, 0);
        ra = 1'b0;
        rb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // A alone: grant after one edge, data after two.
        ra = 1'b1;
        da = 8'h3C;
        cycle();
        check("a_only.grant_a", ga4, 1);
        check("a_only.select", sel4, 0);
        cycle();
        check("a_only.data", dat4, 8'h3C);
        check("a_only.valid", vld4, 1);

        // Reset in the middle of a transfer takes effect immediately.
        async_reset_check("mid_reset");

        // First tie after reset goes to A, then direct handoff to B.
        ra = 1'b1;
        rb = 1'b1;
        da = 8'h11;
        db = 8'hA5;
        cycle();
        check("tie.grant_a", ga4, 1);
        check("tie.grant_b", gb4, 0);
        ra = 1'b0;
        cycle();
        check("handoff.grant_b", gb4, 1);
        cycle();
        check("handoff.data", dat4, 8'hA5);
        check("handoff.valid", vld4, 1);

        // Continuous contention: hold limit forces alternation.
        ra = 1'b1;
        rb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            da = 8'($urandom);
            db = 8'($urandom);
            cycle();
            check("contend.valid", vld4, 1);
        end

        // A alone far past the limit, then B raises and preempts at once.
        rb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            da = 8'($urandom);
            cycle();
        end
        rb = 1'b1;
        cycle();
        check("solo.preempt_b", gb4, 1);

        // Owner gap: A drops for one cycle with B idle.
        rb = 1'b0;
        repeat (3) cycle();
        check("gap.owner_a", ga4, 1);
        ra = 1'b0;
        cycle();
        check("gap.idle", ga4 | gb4, 0);
        check("gap.valid", vld4, 0);
        check("gap.select", sel4, 0);
        ra = 1'b1;
        cycle();
        check("gap.regrant", ga4, 1);

        // Randomized traffic with one asynchronous reset part way through.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            da = 8'($urandom);
            db = 8'($urandom);
            cycle();
            if (i == 200) async_reset_check("rand_reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_2to1.md
Name: bus_arbiter_2to1

Overview:
- Two-requester arbiter that shares one WIDTH-bit bus path between requester A and requester B.
- Contains a 3-state FSM, a round-robin tie pointer, a hold-limit counter and a registered data stage.
- It drives the select of the 2:1 bus mux and registers the selected data with a valid flag.
- It sits between the fetch/ALU result sources and the shared 8-bit internal bus of the CPU.

Parameters:
WIDTH, 8, data width of each requester and of the bus.
MAX_HOLD, 4, maximum consecutive owned cycles while the other side is requesting; legal range >= 1.

Ports:
input_clock  input  1  rising-edge clock.
input_reset_n  input  1  asynchronous, active-low reset.
input_request_a  input  1  A wants the bus; A holds it high for the whole transfer.
input_request_b  input  1  B wants the bus; B holds it high for the whole transfer.
input_data_a  input  WIDTH  A's payload.
input_data_b  input  WIDTH  B's payload.
output_grant_a  output  1  A owns the bus (registered).
output_grant_b  output  1  B owns the bus (registered).
output_select  output  1  mux select: 0 selects A, 1 selects B (registered).
output_data  output  WIDTH  registered bus data.
output_valid  output  1  output_data was captured from the owner this cycle.

Behaviour:
- States: IDLE, OWN_A, OWN_B.
  - output_grant_a = (state==OWN_A); output_grant_b = (state==OWN_B); never both high.
- Reset, asynchronous and immediate even mid-transfer:
  - state = IDLE; both grants = 0; output_select = 0.
  - last_served = B, so A wins the first tie; hold_count = 0.
  - output_data = 0; output_valid = 0.
- Transitions (evaluated at the rising edge):
  - IDLE, only A requesting -> OWN_A.
  - IDLE, only B requesting -> OWN_B.
  - IDLE, both requesting -> the side not equal to last_served.
  - IDLE, neither requesting -> stay in IDLE.
  - OWN_X, own request low, other side requesting -> OWN_other directly, no idle bubble.
  - OWN_X, own request low, other side not requesting -> IDLE.
  - OWN_X, own request high, other side requesting, hold_count == MAX_HOLD-1 -> OWN_other (preemption).
  - OWN_X, otherwise -> stay in OWN_X.
- hold_count:
  - Cleared on every entry to OWN_A or OWN_B, and in IDLE.
  - Increments each cycle the FSM stays in an owned state.
  - Saturates at MAX_HOLD-1; it never wraps.
  - If the owner has been alone longer than MAX_HOLD-1 cycles, a new request from the other side preempts at the next edge.
  - MAX_HOLD=1 gives strict alternation under continuous contention.
- last_served is updated to X when the FSM enters OWN_X.
- output_select:
  - Set to 0 on entry to OWN_A and to 1 on entry to OWN_B.
  - Holds its last value in IDLE, so the mux does not toggle needlessly.
- Data stage:
  - At each edge where state is OWN_X and input_request_x is high: output_data <= input_data_x (via the mux at output_select) and output_valid <= 1.
  - Otherwise output_valid <= 0 and output_data holds its value.
- Latency: a request first sampled high at edge n gives grant high after edge n; first valid data appears after edge n+1.
- Simultaneous drop-and-raise (owner drops, other side raises in the same cycle) is a direct handoff, as above.
- An owner that drops its request for one cycle while it still owns the bus produces output_valid=0 for that cycle.
- A request deasserted before it is granted is simply lost; the arbiter keeps no queue.

Decomposition:
- Shared package (cpu_bus_pkg) holds:
  - The state encoding: IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10.
  - The select constants SEL_A=1'b0 and SEL_B=1'b1.
  - The default bus width of 8.
- One sub-module, mux_2to1_nb:
  - A WIDTH-bit 2:1 mux built from per-bit 1-bit 2:1 muxes.
  - Select 0 passes input A.
  - Instantiated once, feeding the output_data register.
- The FSM, hold counter and last_served pointer live in bus_arbiter_2to1.

Test Plan:
- Reset then A only: reset_n low mid-run, release; request_a=1 with data_a=8'h3C -> grant_a=1 and select=0 after 1 edge; output_data=8'h3C with valid=1 after 2 edges; assert reset_n=0 -> all outputs 0 immediately.
- First tie: both requests rise together from IDLE after reset -> A granted first. After A drops, B is granted at the next edge with no IDLE cycle; data_b=8'hA5 appears one edge later.
- Preemption with MAX_HOLD=4 and both held high: grant pattern A,A,A,A,B,B,B,B,A...; valid=1 on every cycle after the first grant.
- Solo saturation: A alone for 10 cycles, then B raises -> B is granted at the next edge; hold_count never exceeds 3.
- Owner gap: A owns, drops its request for 1 cycle with B idle -> FSM goes to IDLE, valid=0, select stays 0; A re-requests -> regranted after 1 edge.
- MAX_HOLD=1 with both requesting continuously -> grants alternate every cycle; never both high; output_data alternates between data_a and data_b.
